// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - GPR write-port arbiter: pipeline writeback over buffered md results
// Tracks in-flight md destinations in a pending scoreboard for decode stalls.
module gpr_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_addr,
  output logic        issue_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_stall,
  output logic        rt_stall,
  output logic        We,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic        waw_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [31:0]   pending, pend_next;
  logic          waw_q;

  logic          wb_act, nonempty, pop, accept, push;
  logic          issue_block, issue_set;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign head_addr   = fifo_addr[head];
  assign head_data   = fifo_data[head];
  assign wb_act      = wb_we && (wb_addr != 5'd0);
  assign nonempty    = (count != '0);
  assign pop         = !wb_act && nonempty;
  assign accept      = md_valid && (count < FULL);
  // Results for r0 complete the handshake but never occupy a slot.
  assign push        = accept && (md_addr != 5'd0);
  assign issue_block = md_issue && (md_issue_addr != 5'd0) && pending[md_issue_addr];
  assign issue_set   = md_issue && !issue_block && (md_issue_addr != 5'd0);

  always_comb begin
    We          = 1'b0;
    A3          = 5'd0;
    WD          = 32'd0;
    md_ready    = 1'b0;
    issue_stall = 1'b0;
    rs_stall    = 1'b0;
    rt_stall    = 1'b0;
    if (!Rst) begin
      if (wb_act) begin
        We = 1'b1;
        A3 = wb_addr;
        WD = wb_data;
      end else if (nonempty) begin
        We = 1'b1;
        A3 = head_addr;
        WD = head_data;
      end
      md_ready    = (count < FULL);
      issue_stall = issue_block;
      // A same-cycle drain is forwarded by the register-file bypass.
      rs_stall = (rs_addr != 5'd0) && pending[rs_addr] && !(pop && (head_addr == rs_addr));
      rt_stall = (rt_addr != 5'd0) && pending[rt_addr] && !(pop && (head_addr == rt_addr));
    end
  end

  always_comb begin
    pend_next = pending;
    if (pop)       pend_next[head_addr] = 1'b0;
    if (issue_set) pend_next[md_issue_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[tail] <= md_addr;
      fifo_data[tail] <= md_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= 32'd0;
      waw_q   <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      pending <= pend_next;
      if (wb_act && pending[wb_addr]) waw_q <= 1'b1;
    end
  end

  assign waw_err = waw_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb/tb_gpr_write_arbiter.sv - directed vector bench for gpr_write_arbiter
module tb_gpr_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        wb_we, md_issue, md_valid;
  logic [4:0]  wb_addr, md_issue_addr, md_addr, rs_addr, rt_addr;
  logic [31:0] wb_data, md_data;
  logic        issue_stall, md_ready, rs_stall, rt_stall, We, waw_err;
  logic [4:0]  A3;
  logic [31:0] WD;

  int total = 0;
  int bad   = 0;

  gpr_write_arbiter #(.DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr), .issue_stall(issue_stall),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_stall(rs_stall), .rt_stall(rt_stall),
    .We(We), .A3(A3), .WD(WD), .waw_err(waw_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, wbwe, iss, mdv;
    logic [4:0]  wba, issa, mda, rs, rt;
    logic [31:0] wbd, mdd;
    logic [42:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [42:0] pk(logic we, logic [4:0] a3, logic [31:0] wd, logic rdy,
                                     logic ist, logic rss, logic rts, logic waw);
    return {we, a3, wd, rdy, ist, rss, rts, waw};
  endfunction

  task automatic add(logic rst, logic wbwe, logic [4:0] wba, logic [31:0] wbd,
                     logic iss, logic [4:0] issa, logic mdv, logic [4:0] mda, logic [31:0] mdd,
                     logic [4:0] rs, logic [4:0] rt, logic [42:0] exp);
    vec_t v;
    v.rst = rst; v.wbwe = wbwe; v.wba = wba; v.wbd = wbd;
    v.iss = iss; v.issa = issa; v.mdv = mdv; v.mda = mda; v.mdd = mdd;
    v.rs = rs; v.rt = rt; v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic logic [42:0] act();
    return {We, A3, WD, md_ready, issue_stall, rs_stall, rt_stall, waw_err};
  endfunction

  task automatic check(string name, logic [42:0] exp);
    total++;
    if (act() !== exp) begin
      bad++;
      $display("FAIL %s: got {we,a3,wd,rdy,ist,rss,rts,waw}=%h want %h", name, act(), exp);
    end
  endtask

  initial begin
    Rst = 1'b1; wb_we = 0; wb_addr = 0; wb_data = 0; md_issue = 0; md_issue_addr = 0;
    md_valid = 0; md_addr = 0; md_data = 0; rs_addr = 0; rt_addr = 0;

    //   rst we wba wbd        iss issa v mda mdd         rs rt   we a3 wd        rdy ist rss rts waw
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           1, 8,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           0, 0,  1, 8,  32'h1234,   8, 8,  pk(0, 0,  0,           1, 0, 1, 1, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          8, 0,  pk(1, 8,  32'h1234,    1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          8, 8,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 1, 3, 32'h33,      1, 5,  1, 5,  32'h55,     0, 0,  pk(1, 3,  32'h33,      1, 0, 0, 0, 0));
    add(0, 1, 3, 32'h34,      1, 6,  1, 6,  32'h66,     0, 0,  pk(1, 3,  32'h34,      1, 0, 0, 0, 0));
    add(0, 1, 3, 32'h35,      0, 0,  1, 7,  32'h77,     5, 6,  pk(1, 3,  32'h35,      0, 0, 1, 1, 0));
    add(0, 0, 0, 0,           0, 0,  1, 7,  32'h77,     5, 6,  pk(1, 5,  32'h55,      0, 0, 0, 1, 0));
    add(0, 0, 0, 0,           0, 0,  1, 7,  32'h77,     5, 6,  pk(1, 6,  32'h66,      1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(1, 7,  32'h77,      1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           1, 9,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           1, 9,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 1, 0, 0, 0));
    add(0, 0, 0, 0,           1, 0,  0, 0,  0,          0, 9,  pk(0, 0,  0,           1, 0, 0, 1, 0));
    add(0, 0, 0, 0,           1, 4,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 1, 4, 32'hAA,      0, 0,  0, 0,  0,          4, 0,  pk(1, 4,  32'hAA,      1, 0, 1, 0, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  1, 0,  32'hDEAD,   0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  1, 9,  32'h99,     0, 9,  pk(0, 0,  0,           1, 0, 0, 1, 1));
    add(0, 1, 0, 32'hBAD,     0, 0,  0, 0,  0,          0, 9,  pk(1, 9,  32'h99,      1, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 9,  pk(0, 0,  0,           1, 0, 0, 0, 1));
    add(0, 1, 3, 32'h1,       1, 10, 1, 10, 32'h10,     0, 0,  pk(1, 3,  32'h1,       1, 0, 0, 0, 1));
    add(0, 1, 3, 32'h2,       1, 11, 1, 11, 32'h11,     0, 0,  pk(1, 3,  32'h2,       1, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(1, 10, 32'h10,      0, 0, 0, 0, 1));
    add(1, 1, 7, 32'h5,       1, 11, 1, 12, 32'h12,     11, 4, pk(0, 0,  0,           0, 0, 0, 0, 1));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          11, 4, pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           0, 0,  0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));
    add(0, 0, 0, 0,           1, 11, 0, 0,  0,          0, 0,  pk(0, 0,  0,           1, 0, 0, 0, 0));

    // Initial reset: outputs held low during reset, waw_err cleared by the edge.
    @(posedge Clk); #1;
    wb_we = 1; wb_addr = 5; wb_data = 32'hFFFF; md_valid = 1; md_addr = 3; md_issue = 1; md_issue_addr = 2;
    #4 check("reset_hold", pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      Rst = tbl[i].rst; wb_we = tbl[i].wbwe; wb_addr = tbl[i].wba; wb_data = tbl[i].wbd;
      md_issue = tbl[i].iss; md_issue_addr = tbl[i].issa;
      md_valid = tbl[i].mdv; md_addr = tbl[i].mda; md_data = tbl[i].mdd;
      rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
      #4 check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge Clk); #1;
    end

    // Starvation: a full buffer stays full under continuous pipeline writes.
    Rst = 0; md_issue = 0; rs_addr = 0; rt_addr = 0;
    wb_we = 1; wb_addr = 3; wb_data = 32'h7;
    md_valid = 1; md_addr = 20; md_data = 32'h20;
    @(posedge Clk); #1 md_addr = 21; md_data = 32'h21;
    @(posedge Clk); #1 md_addr = 22; md_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #4 check($sformatf("starve%0d", k), pk(1, 3, 32'h7, 0, 0, 0, 0, 0));
      @(posedge Clk); #1;
    end
    wb_we = 0; md_valid = 0;
    #4 check("drain_first", pk(1, 20, 32'h20, 0, 0, 0, 0, 0));
    @(posedge Clk); #1;
    #4 check("drain_second", pk(1, 21, 32'h21, 1, 0, 0, 0, 0));
    @(posedge Clk); #1;
    #4 check("drain_empty", pk(0, 0, 0, 1, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
